// File: rtl/md_issue_ctrl.sv
// Issue controller for the HI/LO multiply/divide unit. It decodes MD ops leaving
// decode, pulses the unit's start inputs and tracks the busy window to stall HI/LO users.
module md_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic       Clk,
  input  logic       Resetn,
  input  logic       d_md_valid,
  input  logic [2:0] d_md_op,
  input  logic       d_mf_valid,
  input  logic       flush,
  output logic       stall,
  output logic       start_mult,
  output logic       start_div,
  output logic       updatemd,
  output logic [2:0] md_control,
  output logic [3:0] busy
);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_e;

  state_e     state_q, state_d;
  logic [3:0] busy_q, busy_d;
  logic [2:0] md_ctrl_q, md_ctrl_d;
  logic       start_mult_q, start_mult_d;
  logic       start_div_q, start_div_d;
  logic       updatemd_q, updatemd_d;

  logic busy_nz, is_mul, is_div, legal, issue;

  assign busy_nz = (busy_q != 4'd0);
  assign is_mul  = (d_md_op[2:1] == 2'b00);
  assign is_div  = (d_md_op[2:1] == 2'b01);
  assign legal   = ~(d_md_op[2] & d_md_op[1]);
  assign stall   = busy_nz & (d_md_valid | d_mf_valid) & ~flush;
  // Redundant with stall while busy, but keeps an issue impossible mid-window by construction.
  assign issue   = d_md_valid & legal & ~stall & ~flush & ~busy_nz;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      busy_q       <= 4'd0;
      md_ctrl_q    <= 3'b000;
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
      updatemd_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      md_ctrl_q    <= md_ctrl_d;
      start_mult_q <= start_mult_d;
      start_div_q  <= start_div_d;
      updatemd_q   <= updatemd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue && is_mul)      state_d = MULT;
        else if (issue && is_div) state_d = DIV;
      end
      MULT, DIV: if (busy_q == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d       = busy_q;
    md_ctrl_d    = md_ctrl_q;
    start_mult_d = 1'b0;
    start_div_d  = 1'b0;
    updatemd_d   = 1'b0;
    if (issue) begin
      md_ctrl_d    = d_md_op;
      updatemd_d   = 1'b1;
      start_mult_d = is_mul;
      start_div_d  = is_div;
      if (is_mul)      busy_d = 4'(MULT_LAT);
      else if (is_div) busy_d = 4'(DIV_LAT);
    end else if (busy_nz) begin
      busy_d = busy_q - 4'd1;
    end
  end

  assign start_mult = start_mult_q;
  assign start_div  = start_div_q;
  assign updatemd   = updatemd_q;
  assign md_control = md_ctrl_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: default-latency instance plus a MULT_LAT=1 instance
// sharing the same stimulus.
module tb_md_issue_ctrl;

  logic       Clk, Resetn;
  logic       d_md_valid, d_mf_valid, flush;
  logic [2:0] d_md_op;
  logic       stall, start_mult, start_div, updatemd;
  logic [2:0] md_control;
  logic [3:0] busy;
  logic       stall1, start_mult1, start_div1, updatemd1;
  logic [2:0] md_control1;
  logic [3:0] busy1;

  int n_cmp = 0;
  int n_err = 0;

  md_issue_ctrl dut (
    .Clk(Clk), .Resetn(Resetn), .d_md_valid(d_md_valid), .d_md_op(d_md_op),
    .d_mf_valid(d_mf_valid), .flush(flush), .stall(stall), .start_mult(start_mult),
    .start_div(start_div), .updatemd(updatemd), .md_control(md_control), .busy(busy)
  );

  md_issue_ctrl #(.MULT_LAT(1)) dut1 (
    .Clk(Clk), .Resetn(Resetn), .d_md_valid(d_md_valid), .d_md_op(d_md_op),
    .d_mf_valid(d_mf_valid), .flush(flush), .stall(stall1), .start_mult(start_mult1),
    .start_div(start_div1), .updatemd(updatemd1), .md_control(md_control1), .busy(busy1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Step to just after the next rising edge; inputs are driven here, outputs checked 1ns later.
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic drv(input logic v, input logic [2:0] op, input logic mf, input logic fl);
    d_md_valid = v;
    d_md_op    = op;
    d_mf_valid = mf;
    flush      = fl;
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b1;
    drv(1'b0, 3'b000, 1'b0, 1'b0);
    Resetn = 1'b0;
    tick();
    tick();
    n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL rst_busy got %0d exp 0", busy); end
    n_cmp++; if (md_control !== 3'b000) begin n_err++; $display("FAIL rst_mdctl got %b exp 000", md_control); end
    n_cmp++; if ({start_mult, start_div, updatemd} !== 3'b000) begin n_err++;
      $display("FAIL rst_pulses got %b exp 000", {start_mult, start_div, updatemd}); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", stall); end
    Resetn = 1'b1;
    tick();
  endtask

  task automatic test_mult_mflo();
    drv(1'b1, 3'b000, 1'b0, 1'b0);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mult_issue_stall got %b exp 0", stall); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      drv(1'b0, 3'b000, 1'b1, 1'b0);
      n_cmp++; if (busy !== 4'(6 - i)) begin n_err++; $display("FAIL mult_busy[%0d] got %0d exp %0d", i, busy, 6 - i); end
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL mult_stall[%0d] got %b exp 1", i, stall); end
      n_cmp++; if (start_mult !== (i == 1)) begin n_err++; $display("FAIL mult_start[%0d] got %b exp %b", i, start_mult, (i == 1)); end
      n_cmp++; if (updatemd !== (i == 1)) begin n_err++; $display("FAIL mult_upd[%0d] got %b exp %b", i, updatemd, (i == 1)); end
      n_cmp++; if (md_control !== 3'b000) begin n_err++; $display("FAIL mult_mdctl[%0d] got %b exp 000", i, md_control); end
    end
    tick();
    n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL mult_end_busy got %0d exp 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mult_end_stall got %b exp 0", stall); end
    drv(1'b0, 3'b000, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    drv(1'b1, 3'b011, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      drv(1'b1, 3'b000, 1'b0, 1'b0);
      n_cmp++; if (busy !== 4'(11 - i)) begin n_err++; $display("FAIL b2b_busy[%0d] got %0d exp %0d", i, busy, 11 - i); end
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall[%0d] got %b exp 1", i, stall); end
      n_cmp++; if (start_div !== (i == 1)) begin n_err++; $display("FAIL b2b_sdiv[%0d] got %b exp %b", i, start_div, (i == 1)); end
      n_cmp++; if (start_mult !== 1'b0) begin n_err++; $display("FAIL b2b_smul[%0d] got %b exp 0", i, start_mult); end
      n_cmp++; if (md_control !== 3'b011) begin n_err++; $display("FAIL b2b_mdctl[%0d] got %b exp 011", i, md_control); end
    end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_accept_stall got %b exp 0", stall); end
    n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL b2b_accept_busy got %0d exp 0", busy); end
    tick();
    drv(1'b0, 3'b000, 1'b0, 1'b0);
    n_cmp++; if (start_mult !== 1'b1) begin n_err++; $display("FAIL b2b_mult_pulse got %b exp 1", start_mult); end
    n_cmp++; if (start_div !== 1'b0) begin n_err++; $display("FAIL b2b_div_quiet got %b exp 0", start_div); end
    n_cmp++; if (md_control !== 3'b000) begin n_err++; $display("FAIL b2b_mult_mdctl got %b exp 000", md_control); end
    n_cmp++; if (busy !== 4'd5) begin n_err++; $display("FAIL b2b_mult_busy got %0d exp 5", busy); end
    tick();
    n_cmp++; if (start_mult !== 1'b0) begin n_err++; $display("FAIL b2b_mult_once got %b exp 0", start_mult); end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL b2b_drain got %0d exp 0", busy); end
  endtask

  task automatic test_mthi_mtlo();
    drv(1'b1, 3'b100, 1'b0, 1'b0);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mtx_stall0 got %b exp 0", stall); end
    tick();
    drv(1'b1, 3'b101, 1'b0, 1'b0);
    n_cmp++; if (updatemd !== 1'b1) begin n_err++; $display("FAIL mtx_upd1 got %b exp 1", updatemd); end
    n_cmp++; if (md_control !== 3'b100) begin n_err++; $display("FAIL mtx_mdctl1 got %b exp 100", md_control); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mtx_stall1 got %b exp 0", stall); end
    n_cmp++; if ({start_mult, start_div} !== 2'b00) begin n_err++; $display("FAIL mtx_start1 got %b exp 00", {start_mult, start_div}); end
    n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL mtx_busy1 got %0d exp 0", busy); end
    tick();
    drv(1'b0, 3'b000, 1'b0, 1'b0);
    n_cmp++; if (updatemd !== 1'b1) begin n_err++; $display("FAIL mtx_upd2 got %b exp 1", updatemd); end
    n_cmp++; if (md_control !== 3'b101) begin n_err++; $display("FAIL mtx_mdctl2 got %b exp 101", md_control); end
    n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL mtx_busy2 got %0d exp 0", busy); end
    tick();
    n_cmp++; if (updatemd !== 1'b0) begin n_err++; $display("FAIL mtx_upd3 got %b exp 0", updatemd); end
    n_cmp++; if (md_control !== 3'b101) begin n_err++; $display("FAIL mtx_hold got %b exp 101", md_control); end
  endtask

  task automatic test_flush_illegal();
    drv(1'b1, 3'b010, 1'b0, 1'b1);
    tick();
    drv(1'b1, 3'b111, 1'b0, 1'b0);
    n_cmp++; if (start_div !== 1'b0) begin n_err++; $display("FAIL flush_sdiv got %b exp 0", start_div); end
    n_cmp++; if (updatemd !== 1'b0) begin n_err++; $display("FAIL flush_upd got %b exp 0", updatemd); end
    n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL flush_busy got %0d exp 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL illegal_stall got %b exp 0", stall); end
    tick();
    drv(1'b1, 3'b000, 1'b0, 1'b0);
    n_cmp++; if ({start_mult, start_div, updatemd} !== 3'b000) begin n_err++;
      $display("FAIL illegal_pulses got %b exp 000", {start_mult, start_div, updatemd}); end
    n_cmp++; if (md_control !== 3'b101) begin n_err++; $display("FAIL illegal_mdctl got %b exp 101", md_control); end
    tick();
    drv(1'b0, 3'b000, 1'b1, 1'b1);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL flushstall_stall got %b exp 0", stall); end
    n_cmp++; if (busy !== 4'd5) begin n_err++; $display("FAIL flushstall_busy got %0d exp 5", busy); end
    tick();
    drv(1'b0, 3'b000, 1'b1, 1'b0);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL flushstall_stall2 got %b exp 1", stall); end
    n_cmp++; if (busy !== 4'd4) begin n_err++; $display("FAIL flushstall_busy2 got %0d exp 4", busy); end
    drv(1'b0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL flushstall_drain got %0d exp 0", busy); end
  endtask

  task automatic test_reset_mid_div();
    drv(1'b1, 3'b010, 1'b0, 1'b0);
    tick();
    drv(1'b0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (busy !== 4'd6) begin n_err++; $display("FAIL rdiv_busy6 got %0d exp 6", busy); end
    n_cmp++; if (md_control !== 3'b010) begin n_err++; $display("FAIL rdiv_mdctl got %b exp 010", md_control); end
    Resetn = 1'b0;
    #1;
    n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL rdiv_async_busy got %0d exp 0", busy); end
    n_cmp++; if (md_control !== 3'b000) begin n_err++; $display("FAIL rdiv_async_mdctl got %b exp 000", md_control); end
    n_cmp++; if ({start_mult, start_div, updatemd} !== 3'b000) begin n_err++;
      $display("FAIL rdiv_async_pulses got %b exp 000", {start_mult, start_div, updatemd}); end
    tick();
    Resetn = 1'b1;
    drv(1'b0, 3'b000, 1'b1, 1'b0);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rdiv_mfhi_stall got %b exp 0", stall); end
    tick();
    n_cmp++; if (busy !== 4'd0) begin n_err++; $display("FAIL rdiv_after_busy got %0d exp 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rdiv_after_stall got %b exp 0", stall); end
    drv(1'b0, 3'b000, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_lat1();
    Resetn = 1'b0;
    #1;
    tick();
    Resetn = 1'b1;
    drv(1'b1, 3'b001, 1'b0, 1'b0);
    tick();
    drv(1'b0, 3'b000, 1'b1, 1'b0);
    n_cmp++; if (busy1 !== 4'd1) begin n_err++; $display("FAIL lat1_busy got %0d exp 1", busy1); end
    n_cmp++; if (start_mult1 !== 1'b1) begin n_err++; $display("FAIL lat1_start got %b exp 1", start_mult1); end
    n_cmp++; if (md_control1 !== 3'b001) begin n_err++; $display("FAIL lat1_mdctl got %b exp 001", md_control1); end
    n_cmp++; if (stall1 !== 1'b1) begin n_err++; $display("FAIL lat1_stall got %b exp 1", stall1); end
    tick();
    n_cmp++; if (busy1 !== 4'd0) begin n_err++; $display("FAIL lat1_busy_end got %0d exp 0", busy1); end
    n_cmp++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL lat1_stall_end got %b exp 0", stall1); end
    n_cmp++; if (start_mult1 !== 1'b0) begin n_err++; $display("FAIL lat1_start_end got %b exp 0", start_mult1); end
    drv(1'b0, 3'b000, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_mult_mflo();
    test_back_to_back();
    test_mthi_mtlo();
    test_flush_illegal();
    test_reset_mid_div();
    test_lat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Pipeline-side initiator for the HI/LO multiply/divide unit. It decodes MD-class instructions leaving the decode stage, drives the unit's `start_mult`/`start_div`/`updatemd`/`md_control` inputs, and models the unit's busy window with its own countdown. It raises `stall` to hold back any HI/LO-touching instruction in decode until the window closes. It sits between the decode/hazard logic and the MD unit, as the requesting end of the start/busy handshake.

## Interface
- `MULT_LAT`, default 5: busy cycles after a mult/multu issue (1..15).
- `DIV_LAT`, default 10: busy cycles after a div/divu issue (1..15).

- `Clk` in 1: sole clock, rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `d_md_valid` in 1: the D-stage instruction is mult/multu/div/divu/mthi/mtlo.
- `d_md_op` in 3: MD opcode. 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo. 110/111 are illegal.
- `d_mf_valid` in 1: the D-stage instruction is mfhi/mflo.
- `flush` in 1: kills the D-stage instruction this cycle, so nothing is issued from it.
- `stall` out 1: combinational. Holds D/F stages.
- `start_mult` out 1: one-cycle pulse for mult/multu issue.
- `start_div` out 1: one-cycle pulse for div/divu issue.
- `updatemd` out 1: one-cycle pulse marking an HI/LO write.
- `md_control` out 3: registered opcode of the last issue. Held between issues.
- `busy` out 4: remaining busy cycles. 0 means idle.

## Operation
- FSM states are IDLE, MULT and DIV, with `busy` as the countdown register.
- An issue occurs in a cycle where `d_md_valid=1`, `stall=0`, `flush=0` and `d_md_op` is legal. On the next edge:
  - `md_control` takes `d_md_op`.
  - `updatemd` is 1.
  - For 000/001: `start_mult` is 1, `busy` loads `MULT_LAT`, and the state goes to MULT.
  - For 010/011: `start_div` is 1, `busy` loads `DIV_LAT`, and the state goes to DIV.
  - For 100/101: no start pulse, `busy` stays 0, and the state stays IDLE.
- In the cycle after an issue, `start_mult`, `start_div` and `updatemd` return to 0, unless another issue occurs that cycle. That is only possible for mthi/mtlo following mthi/mtlo.
- In MULT or DIV, `busy` decrements by 1 each edge. When `busy` goes 1→0 the state returns to IDLE on that same edge.
- `stall = (busy != 0) & (d_md_valid | d_mf_valid) & ~flush`.
  - This covers mthi/mtlo, which must not overwrite HI/LO mid-operation.
  - It also covers a new mult/div, which is never started while busy.
- Illegal opcodes (110/111) with `d_md_valid=1` are ignored: no issue and no stall. No new issue is possible while `busy != 0`.
- Reset (asynchronous, at any time including mid-operation): state IDLE, `busy=0`, `md_control=000`, `start_mult=0`, `start_div=0`, `updatemd=0`. The in-flight operation is abandoned, and the MD unit's own state is not this block's concern.

## Timing
- Issue at cycle t (D accepted). At t+1: start pulse, `updatemd=1`, `busy=LAT`.
- The `busy` sequence for a mult is 5,4,3,2,1 over cycles t+1..t+5, then 0 at t+6.
- A dependent mfhi/mflo or MD op presented from t+1 sees `stall=1` for exactly LAT cycles and is accepted at t+1+LAT.
- Back-to-back case: a second mult present in D at t+1 is stalled until t+6, then issues with its pulse at t+7.
- An mthi/mtlo pair on consecutive cycles gives `updatemd` high for two consecutive cycles with no stall.
- `flush=1` together with a stall condition: `stall=0`, no issue, and the countdown continues unaffected.

## Test plan
- Reset mid-DIV: issue div, pulse `Resetn` low at busy=6. All outputs are 0 asynchronously, and after release `busy` stays 0 and mfhi is not stalled.
- mult at t, mflo in D at t+1..: `start_mult=1`, `updatemd=1`, `md_control=000` at t+1. `busy` 5→1 and `stall=1` over t+1..t+5; `stall=0` at t+6.
- divu followed immediately by mult: `start_div` pulse and `busy=10`, the mult stalls 10 cycles, then `start_mult` pulses once with `md_control=000` and `busy=5`.
- mthi then mtlo on consecutive cycles while idle: `updatemd` is 1,1; `md_control` is 100 then 101; no start pulses; `busy=0`; `stall=0` throughout.
- Flush and illegal opcode: a div with `flush=1` gives no pulse and `busy` stays 0. `d_md_op=111` with `d_md_valid=1` gives no pulse and no stall.
- Parameter override `MULT_LAT=1`: mult gives `busy=1` for one cycle, and a following mfhi stalls exactly one cycle.
